pipe_ex_mem_skid: RTL and testbench
===================================

// Module: pipe_ex_mem_skid
// PURPOSE
//  Elastic EX->MEM pipeline register: 2-entry skid buffer with valid/ready handshake on both sides.
//  Carries MEMWRITE/MEMTOREG/REGWRITE controls, ALU result, store data and destination register.
//  in_ready is registered, so the backpressure path from MEM to EX is not combinational.
//  Adds a synchronous flush (bubble insertion) and an occupancy count for the hazard unit.
// PARAMETERS
//  WIDTH          32  width of RESULTOP and WRDATA
//  AW             5   width of destination register address ARD
//  ZERO_REG_KILL  1   1: REGWRITE stored as REGWRITE_IN & (ARD_IN!=0); 0: stored unchanged
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      synchronous reset, active-high
//  flush         in   1      synchronous flush: discard all held entries
//  in_valid      in   1      EX presents a valid instruction
//  in_ready      out  1      registered; entry accepted when in_valid & in_ready
//  MEMWRITE_IN   in   1      data-memory write enable
//  MEMTOREG_IN   in   1      writeback selects memory data
//  REGWRITE_IN   in   1      register-file write enable
//  RESULTOP_IN   in   WIDTH  ALU result / memory address
//  WRDATA_IN     in   WIDTH  store data
//  ARD_IN        in   AW     destination register
//  out_valid     out  1      main entry holds a valid instruction
//  out_ready     in   1      MEM accepts; pop when out_valid & out_ready
//  MEMWRITE_OUT, MEMTOREG_OUT, REGWRITE_OUT  out 1; RESULTOP_OUT, WRDATA_OUT out WIDTH; ARD_OUT out AW
//  occupancy     out  2      entries held: 0, 1 or 2
// BEHAVIOUR
//  Storage: MAIN register drives the *_OUT ports; SKID register is internal. Both are the same bundle.
//  States: EMPTY (occ 0), ONE (MAIN valid), FULL (MAIN+SKID valid). acc = in_valid&in_ready; pop = out_valid&out_ready.
//  EMPTY: acc -> ONE, MAIN<=in. Otherwise hold.
//  ONE: acc&pop -> ONE, MAIN<=in. acc&!pop -> FULL, SKID<=in.
//       !acc&pop -> EMPTY, MAIN cleared. !acc&!pop -> hold.
//  FULL: in_ready=0 so acc is impossible. pop -> ONE, MAIN<=SKID, SKID cleared. Otherwise hold.
//  in_ready register: next = (next_state != FULL). It is 0 in FULL and 1 in EMPTY/ONE.
//  Latency: EMPTY with acc at edge N -> out_valid=1 and data on *_OUT after edge N. Throughput 1/cycle when out_ready=1.
//  Bubble rule: whenever MAIN is empty, all *_OUT payload ports are 0, so controls are 0 and no write can occur.
//  Ordering: strictly FIFO. An entry is never duplicated or dropped except by flush or rst.
//  Payload in MAIN/SKID is stable while held. *_OUT changes only on a pop or on a load into an empty MAIN.
//  ZERO_REG_KILL=1: ARD_IN=0 with REGWRITE_IN=1 stores REGWRITE=0. All other fields are unchanged.
//  flush: priority over acc/pop. Next edge gives EMPTY, all storage 0, occupancy 0, in_ready=1.
//    The input offered in the flush cycle is dropped even if in_ready=1. A pop in the flush cycle still counts as taken by MEM.
//  rst: highest priority. At the edge: EMPTY, all outputs 0, out_valid=0, occupancy=0, in_ready=0.
//    in_ready rises to 1 at the first edge with rst=0. Reset mid-operation discards every entry.
//  occupancy = 0/1/2 for EMPTY/ONE/FULL, registered with the state.
// TESTING
//  T1 reset: rst=1 for 2 edges with random inputs -> all *_OUT=0, out_valid=0, occupancy=0, in_ready=0.
//     One edge after release -> in_ready=1.
//  T2 pass-through: out_ready=1, accept {1,1,1,A5A5A5A5,55555555,10101} then {0,1,0,12345678,87654321,01010} on consecutive edges.
//     -> each appears one edge later, back to back, out_valid=1. occupancy stays 1.
//  T3 backpressure: out_ready=0, accept RESULTOP 0x11 then 0x22 -> occupancy=2, in_ready=0, *_OUT hold 0x11.
//     Raise out_ready -> 0x11 popped, then 0x22, then out_valid=0 with all-zero payload.
//  T4 flush: FULL (0x11, 0x22) with in_valid=1 carrying 0x33, assert flush one cycle -> occupancy=0, out_valid=0, payload 0.
//     in_ready=1. 0x33 never appears.
//  T5 zero-reg kill: ZERO_REG_KILL=1, REGWRITE_IN=1, ARD_IN=0 -> REGWRITE_OUT=0. With ARD_IN=5'b00011 -> REGWRITE_OUT=1.
//  T6 random: 2000 cycles of random in_valid/out_ready/flush(2%) vs scoreboard queue.
//     -> FIFO order kept, no loss except flush, in_ready never 1 when occupancy=2.

Source files
------------

// File: rtl/pipe_ex_mem_skid.sv
// pipe_ex_mem_skid: 2-entry elastic EX->MEM pipeline register with registered in_ready,
// synchronous flush and occupancy count.
module pipe_ex_mem_skid #(
    parameter int WIDTH         = 32,
    parameter int AW            = 5,
    parameter bit ZERO_REG_KILL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             MEMWRITE_IN,
    input  logic             MEMTOREG_IN,
    input  logic             REGWRITE_IN,
    input  logic [WIDTH-1:0] RESULTOP_IN,
    input  logic [WIDTH-1:0] WRDATA_IN,
    input  logic [AW-1:0]    ARD_IN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             MEMWRITE_OUT,
    output logic             MEMTOREG_OUT,
    output logic             REGWRITE_OUT,
    output logic [WIDTH-1:0] RESULTOP_OUT,
    output logic [WIDTH-1:0] WRDATA_OUT,
    output logic [AW-1:0]    ARD_OUT,
    output logic [1:0]       occupancy
);
    localparam int BW = 3 + 2*WIDTH + AW;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t state, state_n;
    logic [BW-1:0] main_q, skid_q, main_n, skid_n, in_bundle;
    logic acc, pop, rw_in;
    // A write to the zero register is architecturally a no-op, so drop it here
    assign rw_in = REGWRITE_IN & (ZERO_REG_KILL ? (ARD_IN != '0) : 1'b1);
    assign in_bundle = {MEMWRITE_IN, MEMTOREG_IN, rw_in, RESULTOP_IN, WRDATA_IN, ARD_IN};
    assign {MEMWRITE_OUT, MEMTOREG_OUT, REGWRITE_OUT, RESULTOP_OUT, WRDATA_OUT, ARD_OUT} = main_q;
    assign out_valid = state != EMPTY;
    assign occupancy = state;
    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;
    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            state_n = EMPTY;
            main_n  = '0;
            skid_n  = '0;
        end else if (state == EMPTY) begin
            if (acc) begin
                state_n = ONE;
                main_n  = in_bundle;
            end
        end else if (state == ONE) begin
            if (acc && pop) main_n = in_bundle;
            else if (acc) begin
                state_n = FULL;
                skid_n  = in_bundle;
            end else if (pop) begin
                state_n = EMPTY;
                main_n  = '0;
            end
        end else if (pop) begin
            state_n = ONE;
            main_n  = skid_q;
            skid_n  = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_n;
            main_q   <= main_n;
            skid_q   <= skid_n;
            in_ready <= state_n != FULL;
        end
    end
endmodule

// File: tb/tb_pipe_ex_mem_skid.sv
// tb_pipe_ex_mem_skid: directed and random checks of the EX->MEM skid buffer against a queue model.
module tb_pipe_ex_mem_skid;
    localparam int W = 32;
    localparam int A = 5;
    typedef struct packed {
        logic mw, mt, rw;
        logic [W-1:0] res, wd;
        logic [A-1:0] ard;
    } ent_t;
    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic mw_i, mt_i, rw_i, mw_o, mt_o, rw_o;
    logic [W-1:0] res_i, wd_i, res_o, wd_o;
    logic [A-1:0] ard_i, ard_o;
    logic [1:0] occupancy;
    ent_t q[$];
    bit rdy_m = 1'b0;
    bit started = 1'b0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_ex_mem_skid #(.WIDTH(W), .AW(A), .ZERO_REG_KILL(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .MEMWRITE_IN(mw_i), .MEMTOREG_IN(mt_i), .REGWRITE_IN(rw_i),
        .RESULTOP_IN(res_i), .WRDATA_IN(wd_i), .ARD_IN(ard_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .MEMWRITE_OUT(mw_o), .MEMTOREG_OUT(mt_o), .REGWRITE_OUT(rw_o),
        .RESULTOP_OUT(res_o), .WRDATA_OUT(wd_o), .ARD_OUT(ard_o),
        .occupancy(occupancy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a bounded FIFO of at most 2 entries plus a ready bit one edge behind
    always @(posedge clk) begin
        ent_t e;
        bit pop_m, acc_m;
        e = '{mw_i, mt_i, rw_i && (ard_i != 0), res_i, wd_i, ard_i};
        if (rst) begin
            q.delete();
            rdy_m = 1'b0;
        end else if (flush) begin
            q.delete();
            rdy_m = 1'b1;
        end else begin
            pop_m = q.size() > 0 && out_ready;
            acc_m = in_valid && rdy_m;
            if (pop_m) void'(q.pop_front());
            if (acc_m) q.push_back(e);
            rdy_m = q.size() < 2;
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        ent_t e;
        if (started) begin
            e = q.size() > 0 ? q[0] : '0;
            chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
            chk("payload", 128'({mw_o, mt_o, rw_o, res_o, wd_o, ard_o}), 128'(e));
            chk("occupancy", 128'(occupancy), 128'(q.size()));
            chk("in_ready", 128'(in_ready), 128'(rdy_m));
            chk("ready_when_full", 128'(in_ready && occupancy == 2), 128'(0));
        end
    end

    function automatic ent_t mk(input logic [W-1:0] res);
        return '{1'b0, 1'b0, 1'b1, res, ~res, 5'd1};
    endfunction

    task automatic drive(input bit iv, input bit ordy, input bit fl, input ent_t e);
        @(negedge clk);
        in_valid = iv; out_ready = ordy; flush = fl;
        {mw_i, mt_i, rw_i, res_i, wd_i, ard_i} = e;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        ent_t r;
        rst = 1'b1;
        {in_valid, out_ready, flush} = 3'($urandom);
        {mw_i, mt_i, rw_i, res_i, wd_i, ard_i} = {$urandom, $urandom, $urandom};
        @(posedge clk);
        @(negedge clk);
        {in_valid, out_ready, flush} = 3'($urandom);
        {mw_i, mt_i, rw_i, res_i, wd_i, ard_i} = {$urandom, $urandom, $urandom};
        tick;
        chk("t1_in_ready", 128'(in_ready), 128'(0));
        chk("t1_out_valid", 128'(out_valid), 128'(0));
        chk("t1_payload", 128'({mw_o, mt_o, rw_o, res_o, wd_o, ard_o}), 128'(0));
        chk("t1_occ", 128'(occupancy), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1, 0, '0);
        tick;
        chk("t1_ready_rise", 128'(in_ready), 128'(1));

        drive(1, 1, 0, '{1, 1, 1, 32'hA5A5A5A5, 32'h55555555, 5'b10101});
        tick;
        chk("t2_res1", 128'(res_o), 128'(32'hA5A5A5A5));
        chk("t2_ard1", 128'({mw_o, mt_o, rw_o, ard_o}), 128'({3'b111, 5'b10101}));
        chk("t2_occ1", 128'(occupancy), 128'(1));
        drive(1, 1, 0, '{0, 1, 0, 32'h12345678, 32'h87654321, 5'b01010});
        tick;
        chk("t2_res2", 128'({res_o, wd_o}), 128'({32'h12345678, 32'h87654321}));
        chk("t2_ctl2", 128'({out_valid, mw_o, mt_o, rw_o, ard_o}), 128'({4'b1010, 5'b01010}));
        chk("t2_occ2", 128'(occupancy), 128'(1));
        drive(0, 1, 0, '0);
        tick;

        drive(1, 0, 0, mk(32'h11));
        tick;
        drive(1, 0, 0, mk(32'h22));
        tick;
        chk("t3_full", 128'({occupancy, in_ready}), 128'({2'd2, 1'b0}));
        chk("t3_hold", 128'(res_o), 128'(32'h11));
        drive(0, 1, 0, '0);
        tick;
        chk("t3_pop1", 128'({occupancy, res_o}), 128'({2'd1, 32'h22}));
        tick;
        chk("t3_empty", 128'({out_valid, mw_o, mt_o, rw_o, res_o, wd_o, ard_o}), 128'(0));

        drive(1, 0, 0, mk(32'h11));
        tick;
        drive(1, 0, 0, mk(32'h22));
        tick;
        drive(1, 0, 1, mk(32'h33));
        tick;
        chk("t4_flush", 128'({occupancy, out_valid, in_ready}), 128'({2'd0, 1'b0, 1'b1}));
        chk("t4_payload", 128'({mw_o, mt_o, rw_o, res_o, wd_o, ard_o}), 128'(0));
        drive(0, 1, 0, '0);
        tick;
        tick;
        chk("t4_no33", 128'(out_valid), 128'(0));

        drive(1, 1, 0, '{0, 0, 1, 32'h44, 32'h0, 5'd0});
        tick;
        chk("t5_kill", 128'({out_valid, rw_o}), 128'({1'b1, 1'b0}));
        drive(1, 1, 0, '{0, 0, 1, 32'h55, 32'h0, 5'b00011});
        tick;
        chk("t5_keep", 128'({out_valid, rw_o}), 128'({1'b1, 1'b1}));
        drive(0, 1, 0, '0);
        tick;

        for (int i = 0; i < 2000; i++) begin
            r = {$urandom, $urandom, $urandom};
            if ($urandom_range(3) == 0) r.ard = '0;
            drive(1'($urandom), 1'($urandom), $urandom_range(99) < 2, r);
        end
        drive(0, 1, 0, '0);
        tick;
        tick;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
